// File: rtl/switch_debounce_pkg.sv
// Shared constants and types for the board input-conditioning blocks.
// The clock frequency and the 10 ms debounce window are reused by other
// input blocks, so they live here rather than in switch_debounce itself.
package switch_debounce_pkg;

    // Board clock and default debounce window.
    localparam int unsigned CLK_FREQ_HZ           = 50_000_000;
    localparam int unsigned DEBOUNCE_MS           = 10;
    localparam int unsigned DEFAULT_STABLE_CYCLES = (CLK_FREQ_HZ / 1000) * DEBOUNCE_MS;
    localparam int unsigned DEFAULT_CNT_W         = 19;

    // Debounced level of one channel. The state is the level itself.
    typedef enum logic {
        SW_LOW  = 1'b0,
        SW_HIGH = 1'b1
    } sw_state_e;

    // True when a counter of width w can hold the terminal count cycles-1.
    function automatic bit cnt_w_fits(input int unsigned cycles, input int unsigned w);
        return (64'd1 << w) > (64'(cycles) - 64'd1);
    endfunction

endpackage

// File: rtl/switch_debounce_channel.sv
// One switch channel: two-flop synchroniser, stability counter, debounced
// level (2-state FSM), registered rise/fall pulses and a toggle latch.
// The level changes only after the synchronised input has disagreed with it
// for STABLE_CYCLES consecutive cycles; a single agreeing cycle restarts the
// count, so partial counts never accumulate across bounces.
module switch_debounce_channel
    import switch_debounce_pkg::*;
#(
    parameter int STABLE_CYCLES = 8,
    parameter int CNT_W         = 4
) (
    input  logic      CLK,
    input  logic      RST,
    input  logic      sw_raw,
    output sw_state_e state,
    output logic      rise,
    output logic      fall,
    output logic      tgl
);

    // Terminal count: reached after STABLE_CYCLES-1 increments.
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STABLE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;

    // Two-flop synchroniser for the asynchronous pin; nothing between the flops.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= sw_raw;
            sync2 <= sync1;
        end
    end

    // Level FSM with stability counter; pulses and toggle registered alongside.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= SW_LOW;
            cnt   <= '0;
            rise  <= 1'b0;
            fall  <= 1'b0;
            tgl   <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            case (state)
                SW_LOW: begin
                    if (!sync2) begin
                        cnt <= '0;
                    end else if (cnt == LAST_CNT) begin
                        state <= SW_HIGH;
                        cnt   <= '0;
                        rise  <= 1'b1;
                        tgl   <= ~tgl;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                SW_HIGH: begin
                    if (sync2) begin
                        cnt <= '0;
                    end else if (cnt == LAST_CNT) begin
                        state <= SW_LOW;
                        cnt   <= '0;
                        fall  <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= SW_LOW;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/switch_debounce.sv
// Input-conditioning stage between raw board switches and the rest of the
// design. Each of the N_SW channels is synchronised and debounced
// independently; downstream logic uses only SW_DB/SW_RISE/SW_FALL/SW_TGL.
// Every output comes straight from a flop, so there is no combinational path
// from any input to any output.
module switch_debounce
    import switch_debounce_pkg::*;
#(
    parameter int N_SW          = 4,
    parameter int STABLE_CYCLES = int'(DEFAULT_STABLE_CYCLES),
    parameter int CNT_W         = int'(DEFAULT_CNT_W)
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [N_SW-1:0] SW_RAW,
    output logic [N_SW-1:0] SW_DB,
    output logic [N_SW-1:0] SW_RISE,
    output logic [N_SW-1:0] SW_FALL,
    output logic [N_SW-1:0] SW_TGL
);

    // Reject parameter sets the counter cannot represent.
    if (STABLE_CYCLES < 2) begin : g_bad_stable_cycles
        $error("switch_debounce: STABLE_CYCLES must be >= 2");
    end
    if (!cnt_w_fits(STABLE_CYCLES, CNT_W)) begin : g_bad_cnt_w
        $error("switch_debounce: CNT_W too narrow for STABLE_CYCLES-1");
    end

    // Per-channel FSM state, visible for debug; the level output is this state.
    sw_state_e ch_state [N_SW];

    // One independent debounce channel per switch bit.
    for (genvar i = 0; i < N_SW; i++) begin : g_ch
        switch_debounce_channel #(
            .STABLE_CYCLES (STABLE_CYCLES),
            .CNT_W         (CNT_W)
        ) u_ch (
            .CLK    (CLK),
            .RST    (RST),
            .sw_raw (SW_RAW[i]),
            .state  (ch_state[i]),
            .rise   (SW_RISE[i]),
            .fall   (SW_FALL[i]),
            .tgl    (SW_TGL[i])
        );
        assign SW_DB[i] = (ch_state[i] == SW_HIGH);
    end

endmodule

// File: tb/tb_switch_debounce.sv
// Bench for switch_debounce with STABLE_CYCLES=8, CNT_W=4, N_SW=4.
// Stimulus tasks push the expected pulse event (cycle, levels, pulses, toggles)
// into exp_q when they move a pin; the monitor pops one entry every cycle the
// DUT shows any rise/fall pulse. Expected cycle = capture edge + 9.
module tb_switch_debounce;

    localparam int N  = 4;
    localparam int SC = 8;
    localparam int LAT = SC + 1;
    localparam int W  = 48;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic [N-1:0] SW_RAW = '0;
    logic [N-1:0] SW_DB, SW_RISE, SW_FALL, SW_TGL;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [W-1:0] exp_q[$];
    logic [N-1:0] exp_db  = '0;
    logic [N-1:0] exp_tgl = '0;
    logic [N-1:0] prev_pulse = '0;

    switch_debounce #(.N_SW(N), .STABLE_CYCLES(SC), .CNT_W(4)) dut (
        .CLK     (CLK),
        .RST     (RST),
        .SW_RAW  (SW_RAW),
        .SW_DB   (SW_DB),
        .SW_RISE (SW_RISE),
        .SW_FALL (SW_FALL),
        .SW_TGL  (SW_TGL)
    );

    // clock / edge counter
    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc = cyc + 1;

    function automatic logic [W-1:0] mk_ev(input int c, input logic [N-1:0] db,
                                           input logic [N-1:0] r, input logic [N-1:0] f,
                                           input logic [N-1:0] t);
        return {32'(c), db, r, f, t};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // Expected event for pins moved now: the next posedge is the capture edge.
    task automatic push_ev(input logic [N-1:0] rise_m, input logic [N-1:0] fall_m);
        int e0;
        e0 = cyc + 1;
        exp_db  = (exp_db | rise_m) & ~fall_m;
        exp_tgl = exp_tgl ^ rise_m;
        exp_q.push_back(mk_ev(e0 + LAT, exp_db, rise_m, fall_m, exp_tgl));
    endtask

    task automatic set_sw(input int ch, input logic v, input bit expect_ev);
        SW_RAW[ch] = v;
        if (expect_ev) begin
            if (v) push_ev(4'(1 << ch), '0);
            else   push_ev('0, 4'(1 << ch));
        end
    endtask

    task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, want);
        end
    endtask

    // Wait (bounded) for all expected events, then idle to expose spurious ones.
    task automatic drain(input string name);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 60) begin
            tick(1);
            k++;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s_timeout: pending=%0d want 0", name, exp_q.size());
            exp_q.delete();
        end
        tick(12);
    endtask

    task automatic do_reset(input int hold);
        RST = 1'b1;
        tick(hold);
        check("reset_db",   SW_DB,   '0);
        check("reset_rise", SW_RISE, '0);
        check("reset_fall", SW_FALL, '0);
        check("reset_tgl",  SW_TGL,  '0);
        exp_db  = '0;
        exp_tgl = '0;
        exp_q.delete();
        RST = 1'b0;
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge CLK) begin
        logic [N-1:0] pulses;
        logic [W-1:0] want, got;
        if (RST) begin
            prev_pulse = '0;
        end else begin
            pulses = SW_RISE | SW_FALL;
            if (pulses != '0) begin
                total++;
                got = mk_ev(cyc, SW_DB, SW_RISE, SW_FALL, SW_TGL);
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_event: cyc=%0d db=%h rise=%h fall=%h tgl=%h want no event",
                             cyc, SW_DB, SW_RISE, SW_FALL, SW_TGL);
                end else begin
                    want = exp_q.pop_front();
                    if (got !== want) begin
                        bad++;
                        $display("FAIL event: got cyc=%0d db=%h rise=%h fall=%h tgl=%h want cyc=%0d db=%h rise=%h fall=%h tgl=%h",
                                 cyc, SW_DB, SW_RISE, SW_FALL, SW_TGL,
                                 want[47:16], want[15:12], want[11:8], want[7:4], want[3:0]);
                    end
                end
                total++;
                if (((SW_RISE & SW_FALL) != '0) || ((pulses & prev_pulse) != '0)) begin
                    bad++;
                    $display("FAIL pulse_shape: cyc=%0d rise=%h fall=%h prev=%h want single isolated pulses",
                             cyc, SW_RISE, SW_FALL, prev_pulse);
                end
            end
            prev_pulse = pulses;
        end
    end

    // ---------------- test sequence ----------------
    initial begin
        logic [N-1:0] tgl3_want;
        tgl3_want = 4'b0101;

        // Reset state, then all switches held high through release.
        SW_RAW = '0;
        do_reset(2);
        tick(3);
        check("idle_db", SW_DB, '0);
        SW_RAW = 4'hF;
        push_ev(4'hF, '0);
        drain("all_high");
        check("all_high_db",  SW_DB,  4'hF);
        check("all_high_tgl", SW_TGL, 4'hF);

        // Asynchronous clear mid-cycle, well away from a rising edge.
        #2 RST = 1'b1;
        #1;
        check("async_db",  SW_DB,  '0);
        check("async_tgl", SW_TGL, '0);
        check("async_rise", SW_RISE, '0);
        tick(2);
        exp_db  = '0;
        exp_tgl = '0;
        RST = 1'b0;
        push_ev(4'hF, '0);
        drain("rst_release_rise");

        // Clean slate for per-channel tests.
        SW_RAW = '0;
        do_reset(2);
        tick(4);

        // Clean press and release on channel 0.
        set_sw(0, 1'b1, 1'b1);
        drain("press0");
        set_sw(0, 1'b0, 1'b1);
        drain("release0");
        check("release0_tgl", SW_TGL, 4'b0001);

        // Bounce on channel 1: 10 toggles every 3 cycles, ending low, then high.
        for (int i = 0; i < 10; i++) begin
            set_sw(1, ~SW_RAW[1], 1'b0);
            tick(3);
        end
        check("bounce_db", SW_DB, 4'b0000);
        set_sw(1, 1'b1, 1'b1);
        drain("bounce1");

        // Glitch on channel 2: 7 cycles rejected, 8 cycles accepted.
        set_sw(2, 1'b1, 1'b0);
        tick(7);
        set_sw(2, 1'b0, 1'b0);
        tick(20);
        check("glitch7_db", SW_DB, 4'b0010);
        set_sw(2, 1'b1, 1'b1);
        tick(8);
        set_sw(2, 1'b0, 1'b1);
        drain("glitch8");

        // Three presses on channel 3 with channel 0 moving 3 cycles behind.
        for (int p = 0; p < 3; p++) begin
            set_sw(3, 1'b1, 1'b1);
            tick(3);
            set_sw(0, 1'b1, 1'b1);
            drain("par_press");
            check("tgl3_seq", {3'b000, SW_TGL[3]}, {3'b000, tgl3_want[p]});
            set_sw(3, 1'b0, 1'b1);
            tick(3);
            set_sw(0, 1'b0, 1'b1);
            drain("par_release");
        end

        // Reset in the middle of a count: the full latency restarts.
        SW_RAW = '0;
        do_reset(2);
        tick(4);
        set_sw(0, 1'b1, 1'b0);
        tick(5);
        RST = 1'b1;
        tick(2);
        check("midcount_rst_db", SW_DB, '0);
        exp_db  = '0;
        exp_tgl = '0;
        RST = 1'b0;
        push_ev(4'b0001, '0);
        drain("midcount_rise");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/switch_debounce.md
Name: switch_debounce

Overview:
- Input-conditioning stage between the raw board slide switches/buttons and the LED/top-level logic.
- Synchronises each asynchronous switch input into the CLK domain and filters contact bounce.
- Provides a clean debounced level, single-cycle rise/fall pulses, and a per-switch toggle latch.
- Downstream logic consumes only these outputs, never raw SW pins.

Parameters:
- N_SW, 4, number of independent switch channels.
- STABLE_CYCLES, 500000, consecutive CLK cycles a synchronised input must differ from the debounced level before that level changes (10 ms at 50 MHz). Must be >= 2.
- CNT_W, 19, debounce counter width. Must satisfy 2^CNT_W > STABLE_CYCLES-1; elaboration fails otherwise.

Ports:
- CLK  input  1  board clock; all state on posedge.
- RST  input  1  asynchronous, active-high reset.
- SW_RAW  input  N_SW  raw switch pins, asynchronous to CLK.
- SW_DB  output  N_SW  debounced level, registered.
- SW_RISE  output  N_SW  one-cycle pulse when SW_DB goes 0->1.
- SW_FALL  output  N_SW  one-cycle pulse when SW_DB goes 1->0.
- SW_TGL  output  N_SW  toggles on each SW_RISE of that channel.

Behaviour:
- Interface: one clock, CLK. Reset RST is asynchronous and active-high. While RST=1, all flops clear immediately; release is sampled on CLK.
- Reset values: sync1=0, sync2=0, counters=0, SW_DB=0, SW_RISE=0, SW_FALL=0, SW_TGL=0.
- Channels are fully independent; the per-channel logic is replicated N_SW times.
- Synchroniser: two flops per channel. sync1<=SW_RAW[i], sync2<=sync1. No logic between them.
- Per-channel FSM has 2 states, encoded by SW_DB[i]: LOW and HIGH. Counter cnt[i]:
  - If sync2 == SW_DB[i]: cnt <= 0.
  - If sync2 != SW_DB[i] and cnt < STABLE_CYCLES-1: cnt <= cnt+1.
  - If sync2 != SW_DB[i] and cnt == STABLE_CYCLES-1: SW_DB[i] <= sync2, cnt <= 0, pulse issued.
- Glitch rejection: any single cycle where sync2 == SW_DB clears cnt. Partial counts never accumulate across bounces.
- Latency: raw level first captured on edge E0 and held steady thereafter → SW_DB changes on edge E0+STABLE_CYCLES+1.
- Pulses:
  - SW_RISE[i] = 1 for exactly the one cycle after the edge on which SW_DB[i] goes 0->1. Registered, asserted in the same cycle SW_DB shows the new value.
  - SW_FALL[i] is the same for 1->0.
  - Never both high on one channel. Never high two consecutive cycles.
- SW_TGL[i] flips on the same edge SW_DB[i] rises. It is unaffected by falls.
- Counter never wraps; it saturates by construction at STABLE_CYCLES-1 and then clears.
- Reset mid-debounce: partial count is lost. If the switch is held high through reset, after release SW_DB rises with a SW_RISE pulse after the full latency. Switches held high at power-up therefore produce one rise pulse.
- Simultaneous changes on several channels are processed independently. Several pulses may assert in the same cycle.
- No combinational path from any input to any output.

Decomposition:
- Shared constants include: board clock frequency and default STABLE_CYCLES for 10 ms, reused by other input blocks.
- One sub-module is natural: debounce_channel (sync pair, counter, level, pulse and toggle flops for one bit), instantiated N_SW times by a generate loop in switch_debounce.

Test Plan:
All scenarios use STABLE_CYCLES=8, CNT_W=4, N_SW=4.
- Reset: assert RST mid-cycle with SW_RAW=4'hF → all outputs 0 immediately (asynchronous clear). Release, hold SW_RAW=4'hF → SW_DB=4'hF appears 9 edges after first capture edge, with SW_RISE=4'hF for one cycle and SW_TGL=4'hF.
- Clean press: SW_RAW[0] 0->1, held → SW_DB[0]=1 exactly at E0+9, SW_RISE[0] high one cycle. Release held → SW_DB[0]=0 at E0'+9, SW_FALL[0] one cycle, SW_TGL[0] stays 1.
- Bounce: SW_RAW[1] toggles every 3 cycles for 30 cycles, then stays 1 → no SW_DB/SW_RISE change during bounce. SW_DB[1]=1 exactly 9 edges after the final stable capture.
- Glitch: with SW_DB[2]=0, pulse SW_RAW[2] high for 7 cycles → SW_DB[2] stays 0, no pulses. Repeat with 8 cycles → SW_DB[2]=1, one SW_RISE.
- Toggle and parallelism: three clean presses on SW_RAW[3] while SW_RAW[0] changes concurrently → SW_TGL[3] sequence 1,0,1. Channel 0 pulses are independent and correctly timed. No double pulses.
- Reset mid-count: SW_RAW[0] high for 5 cycles, RST pulse, SW_RAW stays high → rise occurs 9 edges after reset release capture, not earlier.
